dmem_ctrl: RTL and testbench

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/dmem_pkg.sv | 18 +
 rtl/dmem_timer.sv | 29 ++
 rtl/dmem_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
// Holds the FSM state encoding, the default timeout and the alignment mask.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_e;

    localparam int unsigned TIMEOUT_DEF   = 255;
    localparam logic [31:0] MISALIGN_MASK = 32'h0000_0003;

    function automatic logic is_misaligned(input logic [31:0] a);
        return |(a & MISALIGN_MASK);
    endfunction

endpackage

// File: rtl/dmem_timer.sv
// Ack-wait counter: loads to 1 when a memory access starts, counts while active.
// tc flags the cycle in which the count has reached TIMEOUT.
module dmem_timer
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic inc,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT + 2);

    logic [W-1:0] cnt;

    // Count access cycles; idle counter rests at zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)    cnt <= '0;
        else if (load) cnt <= W'(1);
        else if (inc)  cnt <= cnt + W'(1);
        else           cnt <= '0;
    end

    assign tc = inc && (cnt == W'(TIMEOUT));

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller between the datapath and a req/ack memory port.
// Optional posted write buffer enabled by defining DMEM_CTRL_WBUF_EN.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Stall,
    output logic        MemFault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    dmem_state_e state, state_nx;

    logic        req, mis, idle, busy;
    logic        fault_now, go_busy, post;
    logic        done_ok, done_to;
    logic        drain_ack, drain_to;
    logic        wb_full;
    logic        tc;
    logic        fault_q;
    logic [31:0] rd_q;

    assign req       = MemRead | MemWrite;
    assign mis       = is_misaligned(Addr);
    assign idle      = (state == IDLE);
    assign busy      = (state == BUSY);
    assign fault_now = idle & req & mis;

`ifdef DMEM_CTRL_WBUF_EN
    assign post    = idle & req & ~mis & ~wb_full & MemWrite;
    assign go_busy = idle & req & ~mis & ~wb_full & ~MemWrite;

    // One-entry posted store: full from capture until drain ack/timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                     wb_full <= 1'b0;
        else if (post)                  wb_full <= 1'b1;
        else if (drain_ack | drain_to)  wb_full <= 1'b0;
    end
`else
    assign post    = 1'b0;
    assign wb_full = 1'b0;
    assign go_busy = idle & req & ~mis;
`endif

    assign done_ok   = busy & mem_ack;
    assign done_to   = busy & tc & ~mem_ack;
    assign drain_ack = wb_full & mem_ack;
    assign drain_to  = wb_full & tc & ~mem_ack;

    dmem_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (go_busy | post),
        .inc   (busy | wb_full),
        .tc    (tc)
    );

    // Next-state decode for the blocking access sequence.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (go_busy) state_nx = BUSY;
            BUSY:    if (done_ok | done_to) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Memory-side request registers, held stable for the whole access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (go_busy | post) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWrite;
            mem_addr  <= Addr;
            mem_wdata <= WriteData;
        end else if (done_ok | done_to | drain_ack | drain_to) begin
            mem_req   <= 1'b0;
        end
    end

    // Load result: captured on load ack, zeroed on timeout or misalign.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 rd_q <= '0;
        else if (done_ok & ~mem_we) rd_q <= mem_rdata;
        else if (done_to)           rd_q <= '0;
        else if (fault_now)         rd_q <= '0;
    end

    // Timeout fault shows up as a one-cycle pulse after the access ends.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fault_q <= 1'b0;
        else        fault_q <= done_to | drain_to;
    end

    assign ReadData = fault_now ? '0 : rd_q;
    assign MemFault = reset & (fault_now | fault_q);
    assign Stall    = reset & ((idle & req & ~mis & ~post) | busy);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed self-checking bench for dmem_ctrl (TIMEOUT=4).
// Posted-store scenario runs only when DMEM_CTRL_WBUF_EN is defined.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [31:0] Addr, WriteData;
    logic [31:0] ReadData;
    logic        Stall, MemFault;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    dmem_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .Addr      (Addr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .Stall     (Stall),
        .MemFault  (MemFault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b0; MemRead = 1'b1; MemWrite = 1'b0;
        Addr = 32'h10; WriteData = '0; mem_ack = 1'b0; mem_rdata = '0;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %0b want 0", Stall); end
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0) begin
            errors++; $display("FAIL rst_req got %0b/%0b want 0/0", mem_req, mem_we);
        end
        checks++;
        if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            errors++; $display("FAIL rst_bus got %h/%h want 0/0", mem_addr, mem_wdata);
        end
        checks++;
        if (ReadData !== 32'h0 || MemFault !== 1'b0) begin
            errors++; $display("FAIL rst_out got %h/%0b want 0/0", ReadData, MemFault);
        end
        MemRead = 1'b0;
        tick;
        reset = 1'b1;
    endtask

    task automatic test_load;
        MemRead = 1'b1; Addr = 32'h10;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || mem_req !== 1'b0) begin
            errors++; $display("FAIL ld_idle got stall=%0b req=%0b want 1/0", Stall, mem_req);
        end
        tick;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin
            errors++;
            $display("FAIL ld_busy1 got %0b %0b %0b %h want 1 1 0 00000010",
                     Stall, mem_req, mem_we, mem_addr);
        end
        tick;
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL ld_busy2 got %0b want 1", Stall); end
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h0000DEAD;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0 || mem_req !== 1'b0 || ReadData !== 32'hCAFEF00D || MemFault !== 1'b0) begin
            errors++;
            $display("FAIL ld_done got %0b %0b %h %0b want 0 0 cafef00d 0",
                     Stall, mem_req, ReadData, MemFault);
        end
        tick;
        MemRead = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadData !== 32'hCAFEF00D || Stall !== 1'b0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL ld_ackign got %h %0b %0b want cafef00d 0 0", ReadData, Stall, mem_req);
        end
        tick;
    endtask

`ifndef DMEM_CTRL_WBUF_EN
    task automatic test_store;
        MemWrite = 1'b1; Addr = 32'h20; WriteData = 32'h12345678;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL st_idle got %0b want 1", Stall); end
        for (int i = 0; i < 2; i++) begin
            tick;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h20 ||
                mem_wdata !== 32'h12345678 || Stall !== 1'b1) begin
                errors++;
                $display("FAIL st_busy%0d got %0b %0b %h %h %0b", i,
                         mem_req, mem_we, mem_addr, mem_wdata, Stall);
            end
        end
        mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'hCAFEF00D) begin
            errors++;
            $display("FAIL st_done got %0b %0b %h want 0 0 cafef00d", mem_req, Stall, ReadData);
        end
        tick;
        MemWrite = 1'b0;
        tick;
    endtask

    task automatic test_both;
        MemRead = 1'b1; MemWrite = 1'b1; Addr = 32'h24; WriteData = 32'hA5A5A5A5;
        tick;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hA5A5A5A5) begin
            errors++; $display("FAIL both_we got %0b %h want 1 a5a5a5a5", mem_we, mem_wdata);
        end
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadData !== 32'hCAFEF00D || Stall !== 1'b0) begin
            errors++; $display("FAIL both_rd got %h %0b want cafef00d 0", ReadData, Stall);
        end
        tick;
        MemRead = 1'b0; MemWrite = 1'b0;
        tick;
    endtask
`endif

    task automatic test_misalign;
        MemRead = 1'b1; Addr = 32'h13;
        @(negedge clk);
        checks++;
        if (MemFault !== 1'b1 || Stall !== 1'b0 || ReadData !== 32'h0 || mem_req !== 1'b0) begin
            errors++;
            $display("FAIL mis_now got %0b %0b %h %0b want 1 0 0 0",
                     MemFault, Stall, ReadData, mem_req);
        end
        tick;
        MemRead = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || MemFault !== 1'b0 || ReadData !== 32'h0) begin
            errors++; $display("FAIL mis_after got %0b %0b %h want 0 0 0", mem_req, MemFault, ReadData);
        end
        tick;
    endtask

    task automatic test_timeout;
        MemRead = 1'b1; Addr = 32'h40;
        for (int i = 0; i < 4; i++) begin
            tick;
            @(negedge clk);
            checks++;
            if (mem_req !== 1'b1 || Stall !== 1'b1 || MemFault !== 1'b0) begin
                errors++;
                $display("FAIL to_busy%0d got %0b %0b %0b want 1 1 0", i, mem_req, Stall, MemFault);
            end
        end
        tick;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0 || MemFault !== 1'b1 || ReadData !== 32'h0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL to_done got %0b %0b %h %0b want 0 1 0 0", mem_req, MemFault, ReadData, Stall);
        end
        tick;
        MemRead = 1'b0;
        @(negedge clk);
        checks++;
        if (MemFault !== 1'b0) begin errors++; $display("FAIL to_pulse got %0b want 0", MemFault); end
        tick;
    endtask

    task automatic test_ack_at_tc;
        MemRead = 1'b1; Addr = 32'h44;
        for (int i = 0; i < 4; i++) tick;
        mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadData !== 32'h55AA55AA || MemFault !== 1'b0 || Stall !== 1'b0) begin
            errors++;
            $display("FAIL tc_ack got %h %0b %0b want 55aa55aa 0 0", ReadData, MemFault, Stall);
        end
        tick;
        MemRead = 1'b0;
        tick;
    endtask

    task automatic test_reset_mid_busy;
        MemRead = 1'b1; Addr = 32'h50;
        tick;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1) begin errors++; $display("FAIL rmb_req got %0b want 1", mem_req); end
        reset = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || Stall !== 1'b0 || ReadData !== 32'h0 || mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL rmb_async got %0b %0b %h %h want 0 0 0 0", mem_req, Stall, ReadData, mem_addr);
        end
        tick;
        reset = 1'b1; Addr = 32'h54;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL rmb_idle got %0b want 1", Stall); end
        tick;
        mem_ack = 1'b1; mem_rdata = 32'h0BADBEEF;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h54) begin
            errors++; $display("FAIL rmb_busy got %0b %h want 1 00000054", mem_req, mem_addr);
        end
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (ReadData !== 32'h0BADBEEF || Stall !== 1'b0) begin
            errors++; $display("FAIL rmb_done got %h %0b want 0badbeef 0", ReadData, Stall);
        end
        tick;
        MemRead = 1'b0;
        tick;
    endtask

`ifdef DMEM_CTRL_WBUF_EN
    task automatic test_back_to_back;
        MemWrite = 1'b1; Addr = 32'h60; WriteData = 32'h1;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL wb_first got %0b want 0", Stall); end
        tick;
        Addr = 32'h64; WriteData = 32'h2;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h60 || mem_we !== 1'b1) begin
            errors++;
            $display("FAIL wb_second got %0b %0b %h %0b want 1 1 00000060 1",
                     Stall, mem_req, mem_addr, mem_we);
        end
        tick;
        mem_ack = 1'b1;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b1) begin errors++; $display("FAIL wb_ackcyc got %0b want 1", Stall); end
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (Stall !== 1'b0) begin errors++; $display("FAIL wb_accept got %0b want 0", Stall); end
        tick;
        MemWrite = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h64 || mem_wdata !== 32'h2) begin
            errors++; $display("FAIL wb_drain2 got %0b %h %h want 1 00000064 2", mem_req, mem_addr, mem_wdata);
        end
        mem_ack = 1'b1;
        tick;
        mem_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_req !== 1'b0) begin errors++; $display("FAIL wb_empty got %0b want 0", mem_req); end
        tick;
    endtask
`endif

    initial begin
        test_reset;
        test_load;
`ifndef DMEM_CTRL_WBUF_EN
        test_store;
        test_both;
`endif
        test_misalign;
        test_timeout;
        test_ack_at_tc;
        test_reset_mid_busy;
`ifdef DMEM_CTRL_WBUF_EN
        test_back_to_back;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
